mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/franken_pkg.sv | 15 +
 rtl/arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/franken_pkg.sv
// Shared types for the I/D memory arbiter: FSM states and port-select encoding.
package franken_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned PERF_W = 16;

endpackage

// File: rtl/arb_pick.sv
// Fetch/data arbitration decision, purely combinational.
// With ARB_RR_EN the port not served last wins a tie; otherwise D always wins.
module arb_pick
  import franken_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last,
  output logic gnt_i,
  output logic gnt_d
);

`ifdef ARB_RR_EN
  logic d_wins_tie;

  assign d_wins_tie = (last == PORT_I);
  assign gnt_d      = d_req & (~i_req | d_wins_tie);
  assign gnt_i      = i_req & (~d_req | ~d_wins_tie);
`else
  logic unused_last;

  assign unused_last = last;
  assign gnt_d       = d_req;
  assign gnt_i       = i_req & ~d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (I) and data (D) ports; ARB_RR_EN selects round-robin.
// Latency: grant -> rvalid >= 1 cycle; one transaction outstanding, new grant the cycle after mem_ready.
// Backpressure: requests wait (unacknowledged) until granted in IDLE; mem_ready stalls BUSY indefinitely.
module mem_arbiter
  import franken_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [PERF_W-1:0] perf_busy;
  logic [PERF_W-1:0] perf_busy_d;

  logic idle;
  logic busy;
  logic last_sel;
  logic pick_i;
  logic pick_d;

  assign idle = (state_q == IDLE);
  assign busy = ~idle;

`ifdef ARB_RR_EN
  logic last_q;
  assign last_sel = last_q;
`else
  assign last_sel = PORT_I;
`endif

  arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last_sel),
    .gnt_i (pick_i),
    .gnt_d (pick_d)
  );

  // Reset gates the grants so a request held during reset is not acknowledged.
  assign i_gnt = reset & idle & pick_i;
  assign d_gnt = reset & idle & pick_d;

  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_be    = busy ? be_q    : '0;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign i_rvalid = (state_q == BUSY_I) & mem_ready;
  assign d_rvalid = (state_q == BUSY_D) & mem_ready;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  assign perf_busy_d = (busy && (perf_busy != '1)) ? perf_busy + PERF_W'(1) : perf_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      perf_busy <= '0;
`ifdef ARB_RR_EN
      last_q    <= PORT_I;
`endif
    end else begin
      perf_busy <= perf_busy_d;
      case (state_q)
        IDLE: begin
          if (d_gnt) begin
            state_q <= BUSY_D;
            addr_q  <= d_addr;
            we_q    <= d_we;
            be_q    <= d_be;
            wdata_q <= d_wdata;
`ifdef ARB_RR_EN
            last_q  <= PORT_D;
`endif
          end else if (i_gnt) begin
            // Fetches are always full-word reads.
            state_q <= BUSY_I;
            addr_q  <= i_addr;
            we_q    <= 1'b0;
            be_q    <= '1;
            wdata_q <= '0;
`ifdef ARB_RR_EN
            last_q  <= PORT_I;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural arbitration/memory model.
module tb_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  logic        last_ig = 1'b0;
  logic        last_dg = 1'b0;
  logic [31:0] resp_mem [16];
  logic [31:0] ref_mem  [16];
  txn_t        exp_q [$];
  logic        m_busy = 1'b0;
  logic        m_last = 1'b0;
  int          m_perf = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: word-indexed, data only meaningful while mem_ready is high.
  assign mem_rdata = mem_ready ? resp_mem[mem_addr[5:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Model + scoreboard + responder write-back, all sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic eg_i;
    logic eg_d;
    txn_t t;
    txn_t nt;
    last_ig = i_gnt;
    last_dg = d_gnt;
    if (!reset) begin
      check("rst_ctrl", 64'({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, mem_be}), '0);
      check("rst_rdata", 64'({i_rdata, d_rdata}), '0);
      check("rst_mem_addr", 64'(mem_addr), '0);
      check("rst_mem_wdata", 64'(mem_wdata), '0);
      m_busy = 1'b0;
      m_last = 1'b0;
      m_perf = 0;
      exp_q.delete();
    end else begin
      eg_i = 1'b0;
      eg_d = 1'b0;
      if (!m_busy) begin
        if (i_req && d_req) begin
`ifdef ARB_RR_EN
          if (m_last) eg_i = 1'b1;
          else        eg_d = 1'b1;
`else
          eg_d = 1'b1;
`endif
        end else begin
          eg_i = i_req;
          eg_d = d_req;
        end
      end
      check("i_gnt", 64'(i_gnt), 64'(eg_i));
      check("d_gnt", 64'(d_gnt), 64'(eg_d));
      check("mem_req", 64'(mem_req), 64'(m_busy));
      if (m_busy && exp_q.size() != 0) begin
        t = exp_q[0];
        check("i_rvalid", 64'(i_rvalid), 64'(!t.port && mem_ready));
        check("d_rvalid", 64'(d_rvalid), 64'(t.port && mem_ready));
        check("mem_we", 64'(mem_we), 64'(t.we));
        check("mem_be", 64'(mem_be), 64'(t.be));
        check("mem_addr", 64'(mem_addr), 64'(t.addr));
        if (t.we) check("mem_wdata", 64'(mem_wdata), 64'(t.wdata));
      end else begin
        check("rvalid_idle", 64'({i_rvalid, d_rvalid}), '0);
      end
      if (i_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", 64'({i_rvalid, d_rvalid}), '0);
        end else begin
          t = exp_q.pop_front();
          check("rvalid_port", 64'({i_rvalid, d_rvalid}), 64'({!t.port, t.port}));
          check(t.port ? "d_rdata" : "i_rdata", 64'(t.port ? d_rdata : i_rdata),
                64'(ref_mem[t.addr[5:2]]));
          if (t.we) ref_mem[t.addr[5:2]] = merge(ref_mem[t.addr[5:2]], t.wdata, t.be);
        end
      end
      if (!i_rvalid) check("i_rdata_zero", 64'(i_rdata), '0);
      if (!d_rvalid) check("d_rdata_zero", 64'(d_rdata), '0);

      if (m_busy && m_perf < 65535) m_perf++;
      if (m_busy && mem_ready) m_busy = 1'b0;
      if (eg_d) begin
        nt = '{port: 1'b1, we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
        exp_q.push_back(nt);
      end else if (eg_i) begin
        nt = '{port: 1'b0, we: 1'b0, be: 4'hF, addr: i_addr, wdata: 32'h0};
        exp_q.push_back(nt);
      end
      if (eg_i || eg_d) begin
        m_busy = 1'b1;
        m_last = eg_d;
      end

      if (mem_req && mem_ready && mem_we)
        resp_mem[mem_addr[5:2]] = merge(resp_mem[mem_addr[5:2]], mem_wdata, mem_be);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic r, input logic [31:0] a);
    i_req  = r;
    i_addr = a;
  endtask

  task automatic set_d(input logic r, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    d_req   = r;
    d_we    = we;
    d_be    = be;
    d_addr  = a;
    d_wdata = wd;
  endtask

  // One random cycle: pending requests hold their payload until granted (or are dropped).
  task automatic step(input int pi, input int pd, input int pr, input int pdrop);
    if (i_req && !last_ig) begin
      if (int'($urandom_range(0, 99)) < pdrop) i_req = 1'b0;
    end else begin
      i_req  = (int'($urandom_range(0, 99)) < pi);
      i_addr = $urandom_range(0, 63);
    end
    if (d_req && !last_dg) begin
      if (int'($urandom_range(0, 99)) < pdrop) d_req = 1'b0;
    end else begin
      d_req   = (int'($urandom_range(0, 99)) < pd);
      d_we    = 1'($urandom_range(0, 1));
      d_be    = 4'($urandom_range(0, 15));
      d_addr  = $urandom_range(0, 63);
      d_wdata = $urandom;
    end
    mem_ready = (int'($urandom_range(0, 99)) < pr);
    cyc();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      resp_mem[k] = $urandom;
      ref_mem[k]  = resp_mem[k];
    end
    resp_mem[4] = 32'h0000_0013;
    ref_mem[4]  = 32'h0000_0013;

    reset     = 1'b1;
    mem_ready = 1'b0;
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    reset = 1'b0;
    set_i(1'b1, 32'h10);
    set_d(1'b1, 1'b0, 4'hF, 32'h18, 32'h0);
    mem_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    mem_ready = 1'b0;
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();

    // Fetch only, ready in the first busy cycle.
    set_i(1'b1, 32'h10);
    cyc();
    set_i(1'b0, 32'h5C);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;

    // Simultaneous requests: D first, I waits for the next IDLE.
    set_i(1'b1, 32'h14);
    set_d(1'b1, 1'b0, 4'hF, 32'h18, 32'h0);
    cyc();
    d_req = 1'b0;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    cyc();
    set_i(1'b0, 32'h0);
    mem_ready = 1'b1;
    cyc();

    // Both held with immediate completion: four back-to-back transactions.
    repeat (8) step(100, 100, 100, 0);
    set_i(1'b0, 32'h0);
    d_req = 1'b0;
    mem_ready = 1'b0;
    cyc();

    // Byte store with slow memory and payload churn while busy.
    set_d(1'b1, 1'b1, 4'b0100, 32'h22, 32'h00AB_0000);
    cyc();
    set_d(1'b0, 1'b0, 4'hF, 32'h80, 32'h1234_5678);
    cyc();
    cyc();
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;

    // Load whose address changes after the grant.
    set_d(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    cyc();
    set_d(1'b0, 1'b0, 4'hF, 32'h80, 32'h0);
    cyc();
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;

    // Reset in the middle of a fetch; ready afterwards must be ignored.
    set_i(1'b1, 32'h30);
    cyc();
    set_i(1'b0, 32'h0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    cyc();

    repeat (2000) step(45, 45, 40, 5);

    set_i(1'b0, 32'h0);
    d_req = 1'b0;
    mem_ready = 1'b1;
    repeat (4) cyc();
    mem_ready = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    check("perf_busy", 64'(dut.perf_busy), 64'(m_perf));
    check("scoreboard_drained", 64'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
